// File: rtl/l1c_mem_arbiter_pkg.sv
// Shared widths and state encoding for the L1 I/D-cache memory-port arbiter.
package l1c_mem_arbiter_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int TYPE_W = 3;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_OWN_I = 2'd1,
      ARB_OWN_D = 2'd2
   } arb_state_t;

endpackage

// File: rtl/l1c_mem_arbiter_if.sv
// Bundle of both cache request ports plus the shared memory port.
interface l1c_mem_arbiter_if #(
   parameter int ADDR_W = l1c_mem_arbiter_pkg::ADDR_W,
   parameter int DATA_W = l1c_mem_arbiter_pkg::DATA_W,
   parameter int TYPE_W = l1c_mem_arbiter_pkg::TYPE_W
) ();

   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_write;
   logic [DATA_W-1:0] i_in;
   logic [TYPE_W-1:0] i_type;
   logic [DATA_W-1:0] i_out;
   logic              i_wait;

   logic              d_req;
   logic [ADDR_W-1:0] d_addr;
   logic              d_write;
   logic [DATA_W-1:0] d_in;
   logic [TYPE_W-1:0] d_type;
   logic [DATA_W-1:0] d_out;
   logic              d_wait;

   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_write;
   logic [DATA_W-1:0] mem_in;
   logic [TYPE_W-1:0] mem_type;
   logic [DATA_W-1:0] mem_out;
   logic              mem_wait;

   // The arbiter's view: caches and memory drive it.
   modport slave (
      input  i_req, i_addr, i_write, i_in, i_type,
      input  d_req, d_addr, d_write, d_in, d_type,
      input  mem_out, mem_wait,
      output i_out, i_wait, d_out, d_wait,
      output mem_req, mem_addr, mem_write, mem_in, mem_type
   );

   modport master (
      output i_req, i_addr, i_write, i_in, i_type,
      output d_req, d_addr, d_write, d_in, d_type,
      output mem_out, mem_wait,
      input  i_out, i_wait, d_out, d_wait,
      input  mem_req, mem_addr, mem_write, mem_in, mem_type
   );

endinterface

// File: rtl/l1c_mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: bit0 = I-cache, bit1 = D-cache; i_last=1 means D was served last.
module l1c_mem_arbiter_rr_arb2 (
   input  logic [1:0] i_req,
   input  logic       i_last,
   output logic [1:0] o_gnt
);

   always_comb begin
      o_gnt = i_req;
      if (i_req == 2'b11) begin
         o_gnt = i_last ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/l1c_mem_arbiter.sv
// Shares one memory port between the L1 I-cache and D-cache; a grant is held for the owner's
// whole burst and released only once its request drops with no beat in flight.
module l1c_mem_arbiter
   import l1c_mem_arbiter_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   l1c_mem_arbiter_if.slave bus
);

   arb_state_t r_state;
   logic       r_lastD;
   logic       r_pend;

   arb_state_t w_state;
   logic       w_ownI;
   logic       w_ownD;
   logic       w_ownerReq;
   logic       w_otherReq;
   logic       w_release;
   logic [1:0] w_gnt;

   // Reset forces the idle view combinationally so memory sees mem_req=0 while rst is high.
   assign w_state    = rst ? ARB_IDLE : r_state;
   assign w_ownI     = (w_state == ARB_OWN_I);
   assign w_ownD     = (w_state == ARB_OWN_D);
   assign w_ownerReq = w_ownI ? bus.i_req : bus.d_req;
   assign w_otherReq = w_ownI ? bus.d_req : bus.i_req;
   assign w_release  = (w_ownI | w_ownD) & ~w_ownerReq & ~bus.mem_wait & ~r_pend;

   l1c_mem_arbiter_rr_arb2 u_rrArb (
      .i_req  ({bus.d_req, bus.i_req}),
      .i_last (r_lastD),
      .o_gnt  (w_gnt)
   );

   always_comb begin
      bus.mem_req   = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_write = 1'b0;
      bus.mem_in    = '0;
      bus.mem_type  = '0;
      bus.i_wait    = bus.i_req;
      bus.d_wait    = bus.d_req;
      if (w_ownI) begin
         bus.mem_req   = bus.i_req;
         bus.mem_addr  = bus.i_addr;
         bus.mem_write = bus.i_write;
         bus.mem_in    = bus.i_in;
         bus.mem_type  = bus.i_type;
         bus.i_wait    = bus.mem_wait;
      end else if (w_ownD) begin
         bus.mem_req   = bus.d_req;
         bus.mem_addr  = bus.d_addr;
         bus.mem_write = bus.d_write;
         bus.mem_in    = bus.d_in;
         bus.mem_type  = bus.d_type;
         bus.d_wait    = bus.mem_wait;
      end
   end

   assign bus.i_out = bus.mem_out;
   assign bus.d_out = bus.mem_out;

   // Handover goes straight to the waiting cache, skipping an idle bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ARB_IDLE;
         r_lastD <= 1'b0;
         r_pend  <= 1'b0;
      end else begin
         r_pend <= bus.mem_wait ? (r_pend | bus.mem_req) : 1'b0;
         case (r_state)
            ARB_IDLE: begin
               if (w_gnt[1]) begin
                  r_state <= ARB_OWN_D;
               end else if (w_gnt[0]) begin
                  r_state <= ARB_OWN_I;
               end
            end
            ARB_OWN_I: begin
               if (w_release) begin
                  r_lastD <= 1'b0;
                  r_state <= w_otherReq ? ARB_OWN_D : ARB_IDLE;
               end
            end
            ARB_OWN_D: begin
               if (w_release) begin
                  r_lastD <= 1'b1;
                  r_state <= w_otherReq ? ARB_OWN_I : ARB_IDLE;
               end
            end
            default: r_state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_l1c_mem_arbiter.sv
// Self-checking bench for l1c_mem_arbiter: directed vector table, corner sequences, random run.
module tb_l1c_mem_arbiter;

   localparam logic [31:0] I_ADDR = 32'h0000_0100;
   localparam logic [31:0] D_ADDR = 32'h0000_2000;
   localparam logic [2:0]  I_TYPE = 3'b100;
   localparam logic [2:0]  D_TYPE = 3'b010;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   // Reference model: who holds the port (0 none, 1 I, 2 D), who went last, beat in flight.
   int   mOwner;
   bit   mLastD;
   bit   mPend;

   l1c_mem_arbiter_if bus ();

   l1c_mem_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       iReq;
      logic       dReq;
      logic       memWait;
      logic       expMemReq;
      logic       expIWait;
      logic       expDWait;
      logic [1:0] expOwner;
   } vec_t;

   vec_t tbl[22];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected outputs derived from the model's owner and the current inputs.
   task automatic checkOutput();
      logic        eReq, eWr, eIW, eDW;
      logic [31:0] eAddr, eIn;
      logic [2:0]  eType;
      eReq = 1'b0; eWr = 1'b0; eAddr = '0; eIn = '0; eType = '0;
      eIW = bus.i_req;
      eDW = bus.d_req;
      if (!rst && mOwner == 1) begin
         eReq = bus.i_req; eWr = bus.i_write; eAddr = bus.i_addr; eIn = bus.i_in; eType = bus.i_type;
         eIW = bus.mem_wait;
      end else if (!rst && mOwner == 2) begin
         eReq = bus.d_req; eWr = bus.d_write; eAddr = bus.d_addr; eIn = bus.d_in; eType = bus.d_type;
         eDW = bus.mem_wait;
      end
      check("mem_req",   64'(bus.mem_req),   64'(eReq));
      check("mem_addr",  64'(bus.mem_addr),  64'(eAddr));
      check("mem_write", 64'(bus.mem_write), 64'(eWr));
      check("mem_in",    64'(bus.mem_in),    64'(eIn));
      check("mem_type",  64'(bus.mem_type),  64'(eType));
      check("i_wait",    64'(bus.i_wait),    64'(eIW));
      check("d_wait",    64'(bus.d_wait),    64'(eDW));
      check("i_out",     64'(bus.i_out),     64'(bus.mem_out));
      check("d_out",     64'(bus.d_out),     64'(bus.mem_out));
   endtask

   // Advance the model by one clock from the arbitration rules.
   task automatic modelStep();
      bit ownerReq, otherReq, nextPend;
      if (rst) begin
         mOwner = 0; mLastD = 0; mPend = 0;
         return;
      end
      ownerReq = (mOwner == 1) ? bus.i_req : (mOwner == 2) ? bus.d_req : 1'b0;
      otherReq = (mOwner == 1) ? bus.d_req : bus.i_req;
      nextPend = bus.mem_wait ? (mPend | ownerReq) : 1'b0;
      if (mOwner == 0) begin
         if (bus.i_req && bus.d_req) mOwner = mLastD ? 1 : 2;
         else if (bus.d_req)         mOwner = 2;
         else if (bus.i_req)         mOwner = 1;
      end else if (!ownerReq && !bus.mem_wait && !mPend) begin
         mLastD = (mOwner == 2);
         mOwner = otherReq ? 3 - mOwner : 0;
      end
      mPend = nextPend;
   endtask

   task automatic applyStimulus(input logic r, input logic ir, input logic dr, input logic mw);
      rst          = r;
      bus.i_req    = ir;
      bus.d_req    = dr;
      bus.mem_wait = mw;
      bus.mem_out  = $urandom;
      @(negedge clk);
      checkOutput();
      @(posedge clk);
      modelStep();
      #1;
   endtask

   task automatic setFixedBundles();
      bus.i_addr = I_ADDR; bus.i_write = 1'b0; bus.i_in = 32'h1111_1111; bus.i_type = I_TYPE;
      bus.d_addr = D_ADDR; bus.d_write = 1'b1; bus.d_in = 32'hDEAD_BEEF; bus.d_type = D_TYPE;
   endtask

   initial begin
      logic [31:0] eAddr;
      logic [2:0]  eType;
      bit          expD;
      checks = 0; errors = 0;
      mOwner = 0; mLastD = 0; mPend = 0;
      rst = 1'b1;
      bus.i_req = 1'b1; bus.d_req = 1'b1; bus.mem_wait = 1'b0; bus.mem_out = '0;
      setFixedBundles();

      // Reset with both requesting, D fill vs I, early-drop of D, then round-robin to I.
      tbl[0]  = '{1,1,1,0, 0,1,1,0};
      tbl[1]  = '{1,1,1,0, 0,1,1,0};
      tbl[2]  = '{0,1,1,1, 0,1,1,0};
      tbl[3]  = '{0,1,1,1, 1,1,1,2};
      tbl[4]  = '{0,1,1,0, 1,1,0,2};
      tbl[5]  = '{0,1,1,1, 1,1,1,2};
      tbl[6]  = '{0,1,1,0, 1,1,0,2};
      tbl[7]  = '{0,1,1,1, 1,1,1,2};
      tbl[8]  = '{0,1,1,0, 1,1,0,2};
      tbl[9]  = '{0,1,1,1, 1,1,1,2};
      tbl[10] = '{0,1,1,0, 1,1,0,2};
      tbl[11] = '{0,1,0,0, 0,1,0,2};
      tbl[12] = '{0,1,0,1, 1,1,0,1};
      tbl[13] = '{0,1,1,0, 1,0,1,1};
      tbl[14] = '{0,0,1,0, 0,0,1,1};
      tbl[15] = '{0,0,1,1, 1,0,1,2};
      tbl[16] = '{0,0,0,1, 0,0,1,2};
      tbl[17] = '{0,0,0,0, 0,0,0,2};
      tbl[18] = '{0,0,0,0, 0,0,0,2};
      tbl[19] = '{0,0,0,0, 0,0,0,0};
      tbl[20] = '{0,1,1,0, 0,1,1,0};
      tbl[21] = '{0,1,1,0, 1,0,1,1};

      @(posedge clk);
      #1;
      for (int k = 0; k < 22; k++) begin
         rst          = tbl[k].rst;
         bus.i_req    = tbl[k].iReq;
         bus.d_req    = tbl[k].dReq;
         bus.mem_wait = tbl[k].memWait;
         bus.mem_out  = $urandom;
         @(negedge clk);
         eAddr = (tbl[k].expOwner == 1) ? I_ADDR : (tbl[k].expOwner == 2) ? D_ADDR : 32'h0;
         eType = (tbl[k].expOwner == 1) ? I_TYPE : (tbl[k].expOwner == 2) ? D_TYPE : 3'h0;
         check($sformatf("tbl%0d_mem_req", k),  64'(bus.mem_req),  64'(tbl[k].expMemReq));
         check($sformatf("tbl%0d_i_wait", k),   64'(bus.i_wait),   64'(tbl[k].expIWait));
         check($sformatf("tbl%0d_d_wait", k),   64'(bus.d_wait),   64'(tbl[k].expDWait));
         check($sformatf("tbl%0d_mem_addr", k), 64'(bus.mem_addr), 64'(eAddr));
         check($sformatf("tbl%0d_mem_type", k), 64'(bus.mem_type), 64'(eType));
         @(posedge clk);
         modelStep();
         #1;
      end

      // Lone I fill: four beats, memory completes every second cycle.
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 1, 0, 1);
      for (int b = 0; b < 4; b++) begin
         applyStimulus(0, 1, 0, 1);
         applyStimulus(0, 1, 0, 0);
      end
      applyStimulus(0, 0, 0, 0);
      bus.i_req = 1'b1;
      #1;
      check("fillIdleAfterDrop_mem_addr", 64'(bus.mem_addr), 64'h0);
      check("fillIdleAfterDrop_mem_req",  64'(bus.mem_req),  64'h0);

      // Alternation: both always wanting the port, grants go D,I,D,I,D,I.
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 1, 1, 0);
      for (int b = 0; b < 6; b++) begin
         expD = (b % 2 == 0);
         check($sformatf("altBurst%0d_mem_addr", b), 64'(bus.mem_addr), expD ? 64'(D_ADDR) : 64'(I_ADDR));
         applyStimulus(0, 1, 1, 0);
         applyStimulus(0, expD ? 1'b1 : 1'b0, expD ? 1'b0 : 1'b1, 1'b0);
         bus.i_req = 1'b1;
         bus.d_req = 1'b1;
         #1;
      end

      // Reset in the middle of an I burst.
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 1, 0, 1);
      applyStimulus(0, 1, 0, 1);
      applyStimulus(0, 1, 0, 0);
      rst = 1'b1;
      bus.mem_wait = 1'b1;
      #1;
      check("rstMid_mem_req", 64'(bus.mem_req), 64'h0);
      check("rstMid_i_wait",  64'(bus.i_wait),  64'h1);
      applyStimulus(1, 1, 0, 1);
      rst = 1'b0;
      #1;
      check("rstMidAfter_mem_req",  64'(bus.mem_req),  64'h0);
      check("rstMidAfter_mem_addr", 64'(bus.mem_addr), 64'h0);
      applyStimulus(0, 1, 1, 0);
      applyStimulus(0, 1, 1, 0);

      // Random traffic against the model, with sticky requests and rare resets.
      applyStimulus(1, 0, 0, 0);
      for (int c = 0; c < 600; c++) begin
         bus.i_addr = $urandom; bus.i_write = 1'($urandom); bus.i_in = $urandom; bus.i_type = 3'($urandom);
         bus.d_addr = $urandom; bus.d_write = 1'($urandom); bus.d_in = $urandom; bus.d_type = 3'($urandom);
         applyStimulus(($urandom_range(0, 63) == 0),
                       ($urandom_range(0, 3) == 0) ? ~bus.i_req : bus.i_req,
                       ($urandom_range(0, 3) == 0) ? ~bus.d_req : bus.d_req,
                       1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
